fx2_slavefifo_ctrl: RTL

Parametrised FPGA-side master for the FX2 synchronous slave-FIFO bus, clocked by ifclk.
- Moves data in both directions between the host and user logic:
  - OUT endpoint (host→FPGA) is drained into a streaming rx interface.
  - tx stream is written to the IN endpoint (FPGA→host), with packet commit via PKTEND.
- Arbitrates round-robin with a burst limit.
- Handles bus turnaround.
- Sits between the FX2 pins (FD/PA/RDY/CTL) and the host-interface command logic.

---
 rtl/fx2_pkg.sv | 29 ++
 rtl/fx2_rx_fifo.sv | 76 +++++++
 rtl/fx2_slavefifo_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fx2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fx2_pkg                                                       |
// | Purpose  : Shared types and constants for the FX2 slave-FIFO master:     |
// |            controller state encoding, FLAGA/FLAGB bit positions and the  |
// |            default FIFOADR values of the OUT (EP2) and IN (EP6) FIFOs.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package fx2_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_TA  = 3'd1,
    RD     = 3'd2,
    WR_TA  = 3'd3,
    WR     = 3'd4,
    PKTEND = 3'd5
  } fx2_state_e;

  // Bit positions inside fx2_flags
  localparam int unsigned FLAG_OUT_NEMPTY = 0;
  localparam int unsigned FLAG_IN_NFULL   = 1;

  // FIFOADR values for the endpoints
  localparam logic [1:0] EP2_ADDR = 2'b00;
  localparam logic [1:0] EP6_ADDR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/fx2_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fx2_rx_fifo                                                   |
// | Purpose  : Small synchronous FIFO that buffers OUT-endpoint words for    |
// |            the rx stream. Push and pop may occur in the same cycle.      |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            push/push_data  - write side                                  |
// |            pop/pop_data    - read side, pop_data shows the oldest word   |
// |            valid           - FIFO not empty                              |
// |            count           - number of stored words (0..DEPTH)           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fx2_rx_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              pop_data,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  // Guards make the FIFO safe even if a caller over-pushes or over-pops.
  assign push_ok = push && (count_q < CW'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;  // DEPTH is a power of two: natural wrap
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem[rd_ptr_q];
  assign valid    = (count_q != '0);
  assign count    = count_q;

endmodule
`default_nettype wire

// File: rtl/fx2_slavefifo_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fx2_slavefifo_ctrl                                            |
// | Purpose  : FPGA-side master of the FX2 synchronous slave-FIFO bus.       |
// |            Drains the OUT endpoint into the rx stream and writes the tx  |
// |            stream into the IN endpoint (PKTEND on tx_last). Directions   |
// |            are arbitrated round-robin with a burst limit, and every      |
// |            direction change is preceded by TURNAROUND idle cycles.       |
// | Ports    : ifclk/resetb             - clock, async active-low reset      |
// |            fx2_flags                - [0] OUT not empty, [1] IN not full |
// |            fx2_fd_in/out/oe         - FD bus (tristate built above)      |
// |            fx2_sloe_b/slrd_b/slwr_b/pktend_b - FX2 strobes, active-low   |
// |            fx2_fifo_addr            - FIFOADR[1:0]                       |
// |            rx_data/valid/ready      - OUT-endpoint stream                |
// |            tx_data/valid/last/ready - IN-endpoint stream                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fx2_slavefifo_ctrl
  import fx2_pkg::*;
#(
  parameter int         DW         = 16,
  parameter logic [1:0] OUT_ADDR   = EP2_ADDR,
  parameter logic [1:0] IN_ADDR    = EP6_ADDR,
  parameter int         RX_DEPTH   = 4,
  parameter int         MAX_BURST  = 256,
  parameter int         TURNAROUND = 1
) (
  input  logic          ifclk,
  input  logic          resetb,
  input  logic [2:0]    fx2_flags,
  input  logic [DW-1:0] fx2_fd_in,
  output logic [DW-1:0] fx2_fd_out,
  output logic          fx2_fd_oe,
  output logic          fx2_sloe_b,
  output logic          fx2_slrd_b,
  output logic          fx2_slwr_b,
  output logic          fx2_pktend_b,
  output logic [1:0]    fx2_fifo_addr,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  input  logic          tx_last,
  output logic          tx_ready
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam int CW = $clog2(RX_DEPTH + 1);

  fx2_state_e    state_q, state_d;
  logic          prio_q, prio_d;       // 0: RX favoured, 1: TX favoured
  logic [BW-1:0] burst_q, burst_d;
  logic [TW-1:0] ta_q, ta_d;

  logic          out_nempty;
  logic          in_nfull;
  logic          unused_flag;
  logic          rx_room;
  logic          rx_req;
  logic          tx_req;
  logic          rx_push;
  logic [CW-1:0] rx_count;

  assign out_nempty  = fx2_flags[FLAG_OUT_NEMPTY];
  assign in_nfull    = fx2_flags[FLAG_IN_NFULL];
  assign unused_flag = fx2_flags[2];

  // The read word is captured on the same edge slrd_b is sampled low, so
  // nothing is ever in flight and the room check reduces to the count.
  assign rx_room = (rx_count < CW'(RX_DEPTH));
  assign rx_req  = out_nempty && rx_room;
  assign tx_req  = tx_valid && in_nfull;

  fx2_rx_fifo #(
    .DW    (DW),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (ifclk),
    .rst_n     (resetb),
    .push      (rx_push),
    .push_data (fx2_fd_in),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .valid     (rx_valid),
    .count     (rx_count)
  );

  // Strobes are decoded from the registered state, so an asynchronous reset
  // forces them high immediately without any intermediate low pulse.
  always_comb begin
    state_d       = state_q;
    prio_d        = prio_q;
    burst_d       = burst_q;
    ta_d          = ta_q;
    fx2_sloe_b    = 1'b1;
    fx2_slrd_b    = 1'b1;
    fx2_slwr_b    = 1'b1;
    fx2_pktend_b  = 1'b1;
    fx2_fd_oe     = 1'b0;
    fx2_fd_out    = '0;
    fx2_fifo_addr = OUT_ADDR;
    tx_ready      = 1'b0;
    rx_push       = 1'b0;

    case (state_q)
      IDLE: begin
        ta_d = '0;
        if (rx_req && (!tx_req || !prio_q)) begin
          state_d = RD_TA;
          prio_d  = 1'b1;
        end else if (tx_req) begin
          state_d = WR_TA;
          prio_d  = 1'b0;
        end
      end

      RD_TA: begin
        fx2_sloe_b = 1'b0;
        burst_d    = '0;
        if (ta_q == TW'(TURNAROUND - 1)) state_d = RD;
        else                             ta_d    = ta_q + 1'b1;
      end

      RD: begin
        fx2_sloe_b = 1'b0;
        if (rx_req) begin
          fx2_slrd_b = 1'b0;
          rx_push    = 1'b1;
          if (burst_q != BW'(MAX_BURST)) burst_d = burst_q + 1'b1;
          if (burst_q == BW'(MAX_BURST - 1)) state_d = IDLE;
        end else begin
          state_d = IDLE;
        end
      end

      WR_TA: begin
        fx2_fifo_addr = IN_ADDR;
        fx2_fd_oe     = 1'b1;
        burst_d       = '0;
        if (ta_q == TW'(TURNAROUND - 1)) state_d = WR;
        else                             ta_d    = ta_q + 1'b1;
      end

      WR: begin
        fx2_fifo_addr = IN_ADDR;
        fx2_fd_oe     = 1'b1;
        tx_ready      = tx_req;
        if (tx_req) begin
          fx2_slwr_b = 1'b0;
          fx2_fd_out = tx_data;
          if (burst_q != BW'(MAX_BURST)) burst_d = burst_q + 1'b1;
          // A packet end takes precedence over the burst limit.
          if (tx_last)                            state_d = PKTEND;
          else if (burst_q == BW'(MAX_BURST - 1)) state_d = IDLE;
        end else begin
          state_d = IDLE;
        end
      end

      PKTEND: begin
        fx2_fifo_addr = IN_ADDR;
        fx2_fd_oe     = 1'b1;
        fx2_pktend_b  = 1'b0;
        state_d       = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      burst_q <= '0;
      ta_q    <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      burst_q <= burst_d;
      ta_q    <= ta_d;
    end
  end

endmodule
`default_nettype wire
